param_register_file: RTL and testbench
======================================

// Module: param_register_file
// PURPOSE
//  Next-generation datapath register file: parametrised width/depth, two write ports, two combinational read ports.
//  Adds a per-register busy scoreboard for in-flight loads.
//  Sits between decode (rs0/rs1 lookup, busy check) and writeback (ALU on port 0, load unit on port 1).
//  Register 0 is hardwired to zero.
// PARAMETERS
//  DATA_W  16  register width in bits
//  ADDR_W  4   address width; DEPTH = 2**ADDR_W registers (reg 0 included)
// PORTS
//  CLK         in   1       clock, all state updates on rising edge
//  RST_N       in   1       asynchronous active-low reset
//  regWrite    in   1       write enable, port 0 (ALU writeback)
//  rd          in   ADDR_W  write address, port 0
//  dataWrite   in   DATA_W  write data, port 0
//  ldWrite     in   1       write enable, port 1 (load writeback); also clears busy[ldRd]
//  ldRd        in   ADDR_W  write address, port 1
//  ldData      in   DATA_W  write data, port 1
//  rsv         in   1       reserve: set busy[rsvRd] (load issued)
//  rsvRd       in   ADDR_W  register being reserved
//  rs0         in   ADDR_W  read address A
//  rs1         in   ADDR_W  read address B
//  A           out  DATA_W  read data for rs0 (combinational)
//  B           out  DATA_W  read data for rs1 (combinational)
//  busyA       out  1       busy[rs0] (combinational)
//  busyB       out  1       busy[rs1] (combinational)
// BEHAVIOUR
//  - Reset (RST_N=0, async): all registers = 0, all busy bits = 0.
//    A/B/busyA/busyB therefore read 0 during and after reset.
//  - Reset mid-operation discards pending writes and reservations; first post-reset edge behaves normally.
//  - Writes: enabled port updates reg[addr] at rising CLK.
//    Write latency 1 cycle: value readable via A/B after the edge.
//  - Both ports write same address in same cycle: port 1 (ldData) wins.
//    Different addresses: both commit.
//  - Address 0: writes from either port ignored; rsv of 0 ignored; A/B read 0; busy[0] always 0.
//  - Scoreboard per register (idle/busy):
//    idle->busy on rsv; busy->idle on ldWrite.
//    Simultaneous rsv and ldWrite to same address: set wins (new load reservation), data still written.
//    Port 0 writes do NOT touch busy.
//    rsv of an already-busy register: stays busy, no error.
//  - Reads: A=reg[rs0], B=reg[rs1], busyA=busy[rs0], busyB=busy[rs1].
//    Pure combinational, no latency. rs0==rs1 legal.
//  - No full/empty condition; addresses wrap naturally within ADDR_W bits, no out-of-range case.
// CONFIGURATION
//  RF_BYPASS_EN defined:
//    A/B forward same-cycle write data when the read address matches an enabled write address (non-zero).
//    Port-1 data takes priority over port-0 data.
//    busyA/busyB read 0 when a same-cycle ldWrite clears that address and no rsv sets it.
//  RF_BYPASS_EN undefined:
//    A/B/busy reflect stored state only; new values visible the cycle after the edge.
// TESTING
//  1 Reset: write 0x1234 to r5, assert RST_N=0 between edges -> A (rs0=5) = 0 immediately; busyA=0.
//  2 r0: regWrite rd=0 data=15; ldWrite ldRd=0 data=7; rsv rsvRd=0 -> A=0, busyA=0 with rs0=0.
//  3 Write/read all regs: for r=1..15 write r via port 0, next cycle read on rs0 and rs1 -> A=B=r.
//  4 Collision: regWrite rd=3 data=0x00AA and ldWrite ldRd=3 data=0x00BB same edge -> A=0x00BB.
//  5 Scoreboard: rsv r7 -> busyA=1 (rs0=7); ldWrite r7 data=9 -> busyA=0, A=9.
//    Same-cycle rsv r7 + ldWrite r7 -> busyA=1, A=new data.
//  6 Bypass: rs0=4, regWrite rd=4 data=0x0042, sample before edge ->
//    A=0x0042 with RF_BYPASS_EN, old r4 value without it.

Source files
------------

// File: rtl/param_register_file.sv
// param_register_file: 2W/2R register file with r0 hardwired to zero and a per-register busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data and busy clears onto the read ports.
module param_register_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] dataWrite,
  input  logic              ldWrite,
  input  logic [ADDR_W-1:0] ldRd,
  input  logic [DATA_W-1:0] ldData,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsvRd,
  input  logic [ADDR_W-1:0] rs0,
  input  logic [ADDR_W-1:0] rs1,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              busyA,
  output logic              busyB
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      if (regWrite && rd != '0) r_regs[rd] <= dataWrite;
      // later assignment gives the load port priority on a same-address collision
      if (ldWrite && ldRd != '0) r_regs[ldRd] <= ldData;
      if (ldWrite) r_busy[ldRd] <= 1'b0;
      if (rsv && rsvRd != '0) r_busy[rsvRd] <= 1'b1;
    end
  end
`ifdef RF_BYPASS_EN
  logic w_ld_a, w_ld_b, w_alu_a, w_alu_b, w_clr_a, w_clr_b;
  always_comb begin
    w_ld_a  = ldWrite && ldRd == rs0 && rs0 != '0;
    w_ld_b  = ldWrite && ldRd == rs1 && rs1 != '0;
    w_alu_a = regWrite && rd == rs0 && rs0 != '0;
    w_alu_b = regWrite && rd == rs1 && rs1 != '0;
    w_clr_a = ldWrite && ldRd == rs0 && !(rsv && rsvRd == rs0);
    w_clr_b = ldWrite && ldRd == rs1 && !(rsv && rsvRd == rs1);
    A     = w_ld_a ? ldData : w_alu_a ? dataWrite : r_regs[rs0];
    B     = w_ld_b ? ldData : w_alu_b ? dataWrite : r_regs[rs1];
    busyA = w_clr_a ? 1'b0 : r_busy[rs0];
    busyB = w_clr_b ? 1'b0 : r_busy[rs1];
  end
`else
  always_comb begin
    A     = r_regs[rs0];
    B     = r_regs[rs1];
    busyA = r_busy[rs0];
    busyB = r_busy[rs1];
  end
`endif
endmodule

// File: tb/tb_param_register_file.sv
// tb_param_register_file: directed and randomized checks against an array-based reference model.
module tb_param_register_file;
  logic        CLK = 1'b0, RST_N = 1'b0;
  logic        regWrite = 1'b0, ldWrite = 1'b0, rsv = 1'b0;
  logic [3:0]  rd = '0, ldRd = '0, rsvRd = '0, rs0 = '0, rs1 = '0;
  logic [15:0] dataWrite = '0, ldData = '0;
  logic [15:0] A, B;
  logic        busyA, busyB;
  int errs = 0, checks = 0;
  logic [15:0] m_regs [16];
  logic        m_busy [16];

  param_register_file #(.DATA_W(16), .ADDR_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .regWrite(regWrite), .rd(rd), .dataWrite(dataWrite),
    .ldWrite(ldWrite), .ldRd(ldRd), .ldData(ldData), .rsv(rsv), .rsvRd(rsvRd),
    .rs0(rs0), .rs1(rs1), .A(A), .B(B), .busyA(busyA), .busyB(busyB)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [15:0] exp_data(input logic [3:0] a);
    if (a == 0) return '0;
`ifdef RF_BYPASS_EN
    if (ldWrite && ldRd == a) return ldData;
    if (regWrite && rd == a) return dataWrite;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [3:0] a);
    if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
    if (ldWrite && ldRd == a && !(rsv && rsvRd == a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  task automatic idle();
    regWrite = 1'b0;
    ldWrite  = 1'b0;
    rsv      = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST_N) begin
      if (regWrite && rd != 0) m_regs[rd] = dataWrite;
      if (ldWrite && ldRd != 0) m_regs[ldRd] = ldData;
      if (ldWrite) m_busy[ldRd] = 1'b0;
      if (rsv && rsvRd != 0) m_busy[rsvRd] = 1'b1;
    end
    #1;
  endtask

  initial begin
    model_reset();
    rs0 = 4'd5;
    rs1 = 4'd9;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_A", A, 16'h0);
    chk("rst_busyB", {15'b0, busyB}, 16'h0);
    RST_N = 1'b1;
    regWrite = 1'b1; rd = 4'd5; dataWrite = 16'h1234;
    rsv = 1'b1; rsvRd = 4'd5;
    tick();
    idle();
    #1;
    chk("t1_pre_A", A, 16'h1234);
    chk("t1_pre_busy", {15'b0, busyA}, 16'h1);
    #1 RST_N = 1'b0;
    #1;
    chk("t1_async_A", A, 16'h0);
    chk("t1_async_busy", {15'b0, busyA}, 16'h0);
    model_reset();
    tick();
    RST_N = 1'b1;
    regWrite = 1'b1; rd = 4'd0; dataWrite = 16'd15;
    ldWrite = 1'b1; ldRd = 4'd0; ldData = 16'd7;
    rsv = 1'b1; rsvRd = 4'd0; rs0 = 4'd0;
    tick();
    idle();
    #1;
    chk("t2_r0_A", A, 16'h0);
    chk("t2_r0_busy", {15'b0, busyA}, 16'h0);
    for (int r = 1; r < 16; r++) begin
      regWrite = 1'b1; rd = 4'(r); dataWrite = 16'(r);
      tick();
      idle();
      rs0 = 4'(r); rs1 = 4'(r);
      #1;
      chk("t3_A", A, 16'(r));
      chk("t3_B", B, 16'(r));
    end
    regWrite = 1'b1; rd = 4'd3; dataWrite = 16'h00AA;
    ldWrite = 1'b1; ldRd = 4'd3; ldData = 16'h00BB;
    tick();
    idle();
    rs0 = 4'd3;
    #1 chk("t4_collide", A, 16'h00BB);
    rsv = 1'b1; rsvRd = 4'd7;
    tick();
    idle();
    rs0 = 4'd7;
    #1 chk("t5_rsv", {15'b0, busyA}, 16'h1);
    ldWrite = 1'b1; ldRd = 4'd7; ldData = 16'd9;
    tick();
    idle();
    #1;
    chk("t5_clr_busy", {15'b0, busyA}, 16'h0);
    chk("t5_clr_A", A, 16'd9);
    ldWrite = 1'b1; ldRd = 4'd7; ldData = 16'h0055;
    rsv = 1'b1; rsvRd = 4'd7;
    tick();
    idle();
    #1;
    chk("t5_both_busy", {15'b0, busyA}, 16'h1);
    chk("t5_both_A", A, 16'h0055);
    rs0 = 4'd4;
    regWrite = 1'b1; rd = 4'd4; dataWrite = 16'h0042;
    #1;
`ifdef RF_BYPASS_EN
    chk("t6_bypass", A, 16'h0042);
`else
    chk("t6_bypass", A, 16'h0004);
`endif
    tick();
    idle();
    #1 chk("t6_after", A, 16'h0042);
    for (int i = 0; i < 400; i++) begin
      regWrite  = 1'($urandom_range(0, 1));
      ldWrite   = 1'($urandom_range(0, 1));
      rsv       = 1'($urandom_range(0, 1));
      rd        = 4'($urandom_range(0, 15));
      ldRd      = ($urandom_range(0, 3) == 0) ? rd : 4'($urandom_range(0, 15));
      rsvRd     = ($urandom_range(0, 3) == 0) ? ldRd : 4'($urandom_range(0, 15));
      rs0       = ($urandom_range(0, 2) == 0) ? ldRd : 4'($urandom_range(0, 15));
      rs1       = ($urandom_range(0, 2) == 0) ? rd : 4'($urandom_range(0, 15));
      dataWrite = 16'($urandom);
      ldData    = 16'($urandom);
      #1;
      chk("rnd_A", A, exp_data(rs0));
      chk("rnd_B", B, exp_data(rs1));
      chk("rnd_busyA", {15'b0, busyA}, {15'b0, exp_busy(rs0)});
      chk("rnd_busyB", {15'b0, busyB}, {15'b0, exp_busy(rs1)});
      if (i == 200) begin
        RST_N = 1'b0;
        #1;
        model_reset();
        chk("rnd_rst_A", A, 16'h0);
        chk("rnd_rst_busyB", {15'b0, busyB}, 16'h0);
        tick();
        RST_N = 1'b1;
      end else begin
        tick();
      end
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
